// File: rtl/sr_multiplier_nb_pkg.sv
// Shared multiplier definitions: FSM state encodings for the shift-and-add
// multiplier and for the FSM_MULT controller.
package sr_multiplier_nb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } sr_state_t;

    typedef enum logic [1:0] {
        FM_IDLE = 2'd0,
        FM_LOAD = 2'd1,
        FM_RUN  = 2'd2,
        FM_DONE = 2'd3
    } fsm_mult_state_t;

endpackage

// File: rtl/sr_mult_datapath.sv
// Shift-and-add datapath: magnitude capture, accumulate/shift per step,
// and two's-complement sign fix into the product register.
module sr_mult_datapath #(
    parameter int WIDTH      = 5,
    parameter int SIGNED_EN  = 0,
    parameter int EARLY_EXIT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 fix,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 last_step,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mult;
    logic [CW-1:0]      count;
    logic               neg;

    logic               signed_eff;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   mult_shift;

    // Magnitudes stay WIDTH-bit unsigned, so the most negative value maps
    // onto 2^(WIDTH-1) without needing an extra bit.
    always_comb begin
        signed_eff = (SIGNED_EN != 0) && signed_mode;
        a_neg      = signed_eff && a[WIDTH-1];
        b_neg      = signed_eff && b[WIDTH-1];
        a_mag      = a_neg ? (~a + 1'b1) : a;
        b_mag      = b_neg ? (~b + 1'b1) : b;
        mult_shift = mult >> 1;
        last_step  = (count == LAST_COUNT) || ((EARLY_EXIT != 0) && (mult_shift == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mult    <= '0;
            count   <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (load) begin
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a_mag};
            mult    <= b_mag;
            count   <= '0;
            neg     <= a_neg ^ b_neg;
        end else if (step) begin
            if (mult[0]) begin
                acc <= acc + mcand;
            end
            mcand <= mcand << 1;
            mult  <= mult_shift;
            count <= count + 1'b1;
        end else if (fix) begin
            product <= neg ? (~acc + 1'b1) : acc;
        end
    end

endmodule

// File: rtl/sr_multiplier_nb.sv
// Sequential shift-and-add multiplier: control FSM around sr_mult_datapath.
// BUSY/DONE are registered; STATE_DBG mirrors the FSM state.
module sr_multiplier_nb
    import sr_multiplier_nb_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int SIGNED_EN  = 0,
    parameter int EARLY_EXIT = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 SIGNED_MODE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   PRODUCT,
    output logic [1:0]           STATE_DBG
);

    sr_state_t state;
    logic      load;
    logic      step;
    logic      fix;
    logic      last_step;

    // Handshake: START is accepted only on an edge where the FSM is idle,
    // which includes the DONE cycle; while BUSY it is ignored.
    always_comb begin
        load      = (state == ST_IDLE) && START;
        step      = (state == ST_CALC);
        fix       = (state == ST_FIX);
        STATE_DBG = state;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state <= ST_CALC;
                        BUSY  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (last_step) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    sr_mult_datapath #(
        .WIDTH      (WIDTH),
        .SIGNED_EN  (SIGNED_EN),
        .EARLY_EXIT (EARLY_EXIT)
    ) u_datapath (
        .clk         (CLK),
        .rst         (RST),
        .load        (load),
        .step        (step),
        .fix         (fix),
        .a           (A),
        .b           (B),
        .signed_mode (SIGNED_MODE),
        .last_step   (last_step),
        .product     (PRODUCT)
    );

endmodule

// File: tb/tb_sr_multiplier_nb.sv
// Directed and random checks for sr_multiplier_nb: fixed-latency, early-exit
// and 8-bit instances share clock, reset and operand buses.
module tb_sr_multiplier_nb;

    logic        CLK;
    logic        RST;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        op_mode;
    logic        start_f, start_e, start_w;
    logic        busy_f, busy_e, busy_w;
    logic        done_f, done_e, done_w;
    logic [9:0]  prod_f, prod_e;
    logic [15:0] prod_w;
    logic [1:0]  st_f, st_e, st_w;

    int          cur_sel;
    logic        busy_m;
    logic        done_m;
    logic [15:0] product_m;
    logic [1:0]  state_m;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    sr_multiplier_nb #(.WIDTH(5), .SIGNED_EN(1), .EARLY_EXIT(0)) u_fix (
        .CLK(CLK), .RST(RST), .START(start_f), .A(op_a[4:0]), .B(op_b[4:0]),
        .SIGNED_MODE(op_mode), .BUSY(busy_f), .DONE(done_f), .PRODUCT(prod_f),
        .STATE_DBG(st_f)
    );

    sr_multiplier_nb #(.WIDTH(5), .SIGNED_EN(1), .EARLY_EXIT(1)) u_early (
        .CLK(CLK), .RST(RST), .START(start_e), .A(op_a[4:0]), .B(op_b[4:0]),
        .SIGNED_MODE(op_mode), .BUSY(busy_e), .DONE(done_e), .PRODUCT(prod_e),
        .STATE_DBG(st_e)
    );

    sr_multiplier_nb #(.WIDTH(8), .SIGNED_EN(1), .EARLY_EXIT(0)) u_wide (
        .CLK(CLK), .RST(RST), .START(start_w), .A(op_a), .B(op_b),
        .SIGNED_MODE(op_mode), .BUSY(busy_w), .DONE(done_w), .PRODUCT(prod_w),
        .STATE_DBG(st_w)
    );

    always_comb begin
        busy_m    = busy_f;
        done_m    = done_f;
        product_m = {6'd0, prod_f};
        state_m   = st_f;
        if (cur_sel == 1) begin
            busy_m    = busy_e;
            done_m    = done_e;
            product_m = {6'd0, prod_e};
            state_m   = st_e;
        end else if (cur_sel == 2) begin
            busy_m    = busy_w;
            done_m    = done_w;
            product_m = prod_w;
            state_m   = st_w;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_start(input logic v);
        start_f = (cur_sel == 0) ? v : 1'b0;
        start_e = (cur_sel == 1) ? v : 1'b0;
        start_w = (cur_sel == 2) ? v : 1'b0;
    endtask

    // Called just after the accept edge; counts edges until DONE is seen.
    task automatic wait_done(output int lat, output int busy_hi, output logic [15:0] prod);
        lat     = -1;
        busy_hi = 0;
        prod    = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK);
            #1;
            if (busy_m) busy_hi++;
            if (done_m) begin
                lat  = k;
                prod = product_m;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'(done_m), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic mode,
                          output int lat, output int busy_hi, output logic [15:0] prod);
        @(negedge CLK);
        op_a    = a;
        op_b    = b;
        op_mode = mode;
        set_start(1'b1);
        @(posedge CLK);
        #1;
        set_start(1'b0);
        op_a = $urandom_range(0, 255);
        op_b = $urandom_range(0, 255);
        op_mode = 1'($urandom_range(0, 1));
        wait_done(lat, busy_hi, prod);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          lat;
        int          busy_hi;
        int          dones;
        logic [15:0] prod;
        logic [15:0] exp;
        int          sa;
        int          sb;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rm;

        n_checks = 0;
        n_errors = 0;
        cur_sel  = 0;
        RST      = 1'b1;
        op_a     = '0;
        op_b     = '0;
        op_mode  = 1'b0;
        start_f  = 1'b0;
        start_e  = 1'b0;
        start_w  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", 32'(busy_f), 32'd0);
        check("rst_done", 32'(done_f), 32'd0);
        check("rst_product", 32'(prod_f), 32'd0);
        check("rst_state", 32'(st_f), 32'd0);
        check("rst_product_w", 32'(prod_w), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Fixed latency, unsigned 31*31
        cur_sel = 0;
        run_op(8'd31, 8'd31, 1'b0, lat, busy_hi, prod);
        check("u31x31_prod", 32'(prod), 32'd961);
        check("u31x31_lat", 32'(lat), 32'd6);
        check("u31x31_busy_cycles", 32'(busy_hi), 32'd5);
        check("u31x31_busy_at_done", 32'(busy_m), 32'd0);

        run_op(8'd0, 8'd0, 1'b0, lat, busy_hi, prod);
        check("u0x0_prod", 32'(prod), 32'd0);
        check("u0x0_lat", 32'(lat), 32'd6);

        run_op(8'd6, 8'd0, 1'b0, lat, busy_hi, prod);
        check("u6x0_prod", 32'(prod), 32'd0);

        // Signed: -16*-16 = 256, -3*7 = -21 (10'h3EB)
        run_op(8'h10, 8'h10, 1'b1, lat, busy_hi, prod);
        check("s_m16xm16", 32'(prod), 32'd256);
        run_op(8'h1D, 8'h07, 1'b1, lat, busy_hi, prod);
        check("s_m3x7", 32'(prod), 32'h3EB);
        check("s_m3x7_lat", 32'(lat), 32'd6);
        run_op(8'h05, 8'h1A, 1'b1, lat, busy_hi, prod);
        check("s_5xm6", 32'(prod), 32'h3E2);
        run_op(8'h1D, 8'h07, 1'b0, lat, busy_hi, prod);
        check("u29x7_unsigned_mode", 32'(prod), 32'd203);

        // Early exit instance
        cur_sel = 1;
        run_op(8'd13, 8'd1, 1'b0, lat, busy_hi, prod);
        check("ee_13x1_prod", 32'(prod), 32'd13);
        check("ee_13x1_lat", 32'(lat), 32'd2);
        run_op(8'd13, 8'd0, 1'b0, lat, busy_hi, prod);
        check("ee_13x0_prod", 32'(prod), 32'd0);
        check("ee_13x0_lat", 32'(lat), 32'd2);
        run_op(8'd5, 8'd6, 1'b0, lat, busy_hi, prod);
        check("ee_5x6_prod", 32'(prod), 32'd30);
        check("ee_5x6_lat", 32'(lat), 32'd4);
        run_op(8'd31, 8'd31, 1'b0, lat, busy_hi, prod);
        check("ee_31x31_lat", 32'(lat), 32'd6);

        // START ignored while busy, operands changing after accept
        cur_sel = 0;
        @(negedge CLK);
        op_a    = 8'd9;
        op_b    = 8'd7;
        op_mode = 1'b0;
        set_start(1'b1);
        @(posedge CLK);
        #1;
        set_start(1'b0);
        dones = 0;
        lat   = -1;
        prod  = '0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge CLK);
            #1;
            if (done_m) begin
                dones++;
                lat  = k;
                prod = product_m;
            end
            if (k >= 2 && k <= 4) begin
                op_a    = 8'd1;
                op_b    = 8'd1;
                op_mode = 1'b1;
                set_start(1'b1);
            end else begin
                op_a = 8'h1F;
                op_b = 8'h1F;
                set_start(1'b0);
            end
        end
        check("ignore_start_prod", 32'(prod), 32'd63);
        check("ignore_start_dones", 32'(dones), 32'd1);
        check("ignore_start_lat", 32'(lat), 32'd6);

        // Back-to-back: START held into the DONE cycle
        @(negedge CLK);
        op_a    = 8'd2;
        op_b    = 8'd3;
        op_mode = 1'b0;
        set_start(1'b1);
        @(posedge CLK);
        #1;
        wait_done(lat, busy_hi, prod);
        check("b2b_first_prod", 32'(prod), 32'd6);
        op_a = 8'd5;
        op_b = 8'd5;
        @(posedge CLK);
        #1;
        set_start(1'b0);
        check("b2b_busy_no_gap", 32'(busy_m), 32'd1);
        check("b2b_state_calc", 32'(state_m), 32'd1);
        wait_done(lat, busy_hi, prod);
        check("b2b_second_prod", 32'(prod), 32'd25);
        check("b2b_second_lat", 32'(lat), 32'd6);

        // Reset mid-operation
        @(negedge CLK);
        op_a    = 8'd31;
        op_b    = 8'd31;
        op_mode = 1'b0;
        set_start(1'b1);
        @(posedge CLK);
        #1;
        set_start(1'b0);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("abort_busy", 32'(busy_m), 32'd0);
        check("abort_product", 32'(product_m), 32'd0);
        check("abort_state", 32'(state_m), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK);
            #1;
            if (done_m) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op(8'd2, 8'd3, 1'b0, lat, busy_hi, prod);
        check("after_abort_prod", 32'(prod), 32'd6);
        check("after_abort_lat", 32'(lat), 32'd6);

        // Random sweep on the 8-bit instance, both modes
        cur_sel = 2;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            sa = rm ? int'($signed(ra)) : int'(ra);
            sb = rm ? int'($signed(rb)) : int'(rb);
            exp_q.push_back(16'(sa * sb));
            run_op(ra, rb, rm, lat, busy_hi, prod);
            exp = exp_q.pop_front();
            check("rand_w8_prod", 32'(prod), 32'(exp));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
